// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer
// Purpose  : Multi-channel two-flop synchronizer and counter-based debouncer
//            for push-buttons and DIP switches. Each channel is independent.
// Revision : 1.0 - initial release
//
// Ports:
//   clk      in   1      system clock, rising edge
//   rst_n    in   1      synchronous active-low reset
//   pins_i   in   WIDTH  raw asynchronous pin levels
//   level_o  out  WIDTH  debounced, synchronized levels
//   rise_o   out  WIDTH  one-cycle pulse on debounced 0->1 (pulse build only)
//   fall_o   out  WIDTH  one-cycle pulse on debounced 1->0 (pulse build only)
//
// Configuration macro:
//   DEBOUNCE_PULSE_EN  when defined, rise_o/fall_o and their registers exist.
// ============================================================================
module input_debouncer #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RESET_LEVEL     = 0,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pins_i,
`ifdef DEBOUNCE_PULSE_EN
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
`endif
  output logic [WIDTH-1:0] level_o
);

  // Terminal count: the sample that reaches this value is the
  // DEBOUNCE_CYCLES-th consecutive differing sample, so the change is accepted.
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             c_RST_LVL = (RESET_LEVEL != 0);

  for (genvar n = 0; n < WIDTH; n++) begin : g_ch
    logic             s1_q;
    logic             s2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    // Accept when the synchronized sample has disagreed with the stable
    // level for DEBOUNCE_CYCLES consecutive samples.
    assign accept = (s2_q != stable_q) && (cnt_q == c_CNT_MAX);

    always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (s2_q == stable_q) begin
        // Any agreeing sample restarts the count: this is the glitch filter.
        cnt_d = '0;
      end else if (accept) begin
        stable_d = s2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_q     <= c_RST_LVL;
        s2_q     <= c_RST_LVL;
        stable_q <= c_RST_LVL;
        cnt_q    <= '0;
      end else begin
        s1_q     <= pins_i[n];
        s2_q     <= s1_q;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
      end
    end

    assign level_o[n] = stable_q;

`ifdef DEBOUNCE_PULSE_EN
    logic rise_q;
    logic fall_q;
    logic rise_d;
    logic fall_d;

    // Pulses are registered alongside stable_q, so they are high exactly in
    // the cycle after the accepted edge. Only one direction can be accepted
    // per edge, so rise and fall are mutually exclusive.
    assign rise_d = accept &  s2_q;
    assign fall_d = accept & ~s2_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign rise_o[n] = rise_q;
    assign fall_o[n] = fall_q;
`endif
  end

endmodule
`default_nettype wire
